// File: rtl/seg_pattern_decoder_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg_pattern_decoder_if                                              |
// | Scanned segment bus in, decoded digit register file out.            |
// | SEG_DP_EN adds the decimal-point input and per-digit dp mask.       |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface seg_pattern_decoder_if #(
  parameter int NUM_DIGITS = 4
);
  logic                          clear;
  logic [6:0]                    seg_in;
  logic [$clog2(NUM_DIGITS)-1:0] dig_sel;
  logic                          dig_en;
  logic [4*NUM_DIGITS-1:0]       value_out;
  logic [NUM_DIGITS-1:0]         valid_mask;
  logic [NUM_DIGITS-1:0]         err_mask;
  logic                          frame_done;
`ifdef SEG_DP_EN
  logic                          seg_dp;
  logic [NUM_DIGITS-1:0]         dp_mask;

  modport master (
    output clear, seg_in, dig_sel, dig_en, seg_dp,
    input  value_out, valid_mask, err_mask, frame_done, dp_mask
  );
  modport slave (
    input  clear, seg_in, dig_sel, dig_en, seg_dp,
    output value_out, valid_mask, err_mask, frame_done, dp_mask
  );
`else
  modport master (
    output clear, seg_in, dig_sel, dig_en,
    input  value_out, valid_mask, err_mask, frame_done
  );
  modport slave (
    input  clear, seg_in, dig_sel, dig_en,
    output value_out, valid_mask, err_mask, frame_done
  );
`endif
endinterface
`default_nettype wire

// File: rtl/seg_pattern_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg_pattern_decoder                                                 |
// | Filters and decodes a scanned active-low 7-segment bus per digit.   |
// | Optional feature macro: SEG_DP_EN (decimal point sample + dp_mask). |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module seg_pattern_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic                  clk,
  input logic                  rst,
  seg_pattern_decoder_if.slave bus
);
  localparam int                 C_SEL_W  = $clog2(NUM_DIGITS);
  localparam int unsigned        C_NUM_I  = NUM_DIGITS;
  localparam logic [C_SEL_W:0]   C_NUM    = C_NUM_I[C_SEL_W:0];
  localparam logic [7:0]         C_STABLE = 8'(STABLE_CYCLES);
`ifdef SEG_DP_EN
  localparam int                 C_SMP_W  = 8 + C_SEL_W;
`else
  localparam int                 C_SMP_W  = 7 + C_SEL_W;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  logic [6:0]          s_seg_q, s_seg_d;
  logic [C_SEL_W-1:0]  s_sel_q, s_sel_d;
  logic                s_en_q, s_en_d;
  logic [C_SMP_W-1:0]  prev_q, prev_d;
  logic [7:0]          cnt_q, cnt_d;
  state_t              state_q, state_d;
  logic [3:0]          value_q [NUM_DIGITS];
  logic [3:0]          value_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] valid_q, valid_d;
  logic [NUM_DIGITS-1:0] err_q, err_d;
  logic [NUM_DIGITS-1:0] seen_q, seen_d;
  logic                frame_done_q, frame_done_d;
`ifdef SEG_DP_EN
  logic                s_dp_q, s_dp_d;
  logic [NUM_DIGITS-1:0] dp_q, dp_d;
`endif

  logic                w_en;
  logic [C_SMP_W-1:0]  w_smp;
  logic                w_chg;
  logic [7:0]          w_cnt_nxt;
  logic                w_latch;
  logic [4:0]          w_dec;
  logic                w_blank;

  // Returns {legal, nibble}; legal=0 for blank and for illegal patterns.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b0000001: r = {1'b1, 4'h0};
      7'b1111001: r = {1'b1, 4'h1};
      7'b0010010: r = {1'b1, 4'h2};
      7'b0000110: r = {1'b1, 4'h3};
      7'b1001100: r = {1'b1, 4'h4};
      7'b0100100: r = {1'b1, 4'h5};
      7'b0100000: r = {1'b1, 4'h6};
      7'b0001111: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0001100: r = {1'b1, 4'h9};
      7'b0001000: r = {1'b1, 4'hA};
      7'b1100000: r = {1'b1, 4'hB};
      7'b0110001: r = {1'b1, 4'hC};
      7'b1000010: r = {1'b1, 4'hD};
      7'b0110000: r = {1'b1, 4'hE};
      7'b0111000: r = {1'b1, 4'hF};
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  assign w_en = s_en_q && ({1'b0, s_sel_q} < C_NUM);
`ifdef SEG_DP_EN
  assign w_smp = {s_dp_q, s_seg_q, s_sel_q};
`else
  assign w_smp = {s_seg_q, s_sel_q};
`endif
  assign w_chg     = (w_smp != prev_q);
  assign w_cnt_nxt = !w_en ? 8'd0 :
                     w_chg ? 8'd1 :
                     (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  // The count hits the threshold once per run; HOLD only blocks the saturated case.
  assign w_latch   = w_en && (w_cnt_nxt == C_STABLE) && ((state_q != ST_HOLD) || w_chg);
  assign w_dec     = decode(s_seg_q);
  assign w_blank   = (s_seg_q == 7'h7F);

  always_comb begin
    s_seg_d      = bus.seg_in;
    s_sel_d      = bus.dig_sel;
    s_en_d       = bus.dig_en;
    prev_d       = w_smp;
    cnt_d        = w_cnt_nxt;
    value_d      = value_q;
    valid_d      = valid_q;
    err_d        = err_q;
    seen_d       = seen_q;
    frame_done_d = 1'b0;
`ifdef SEG_DP_EN
    s_dp_d       = bus.seg_dp;
    dp_d         = dp_q;
`endif

    if (!w_en)                             state_d = ST_IDLE;
    else if (w_latch)                      state_d = ST_HOLD;
    else if (state_q == ST_HOLD && !w_chg) state_d = ST_HOLD;
    else                                   state_d = ST_SETTLE;

    if (w_latch) begin
      seen_d[s_sel_q] = 1'b1;
      if (w_dec[4]) begin
        value_d[s_sel_q] = w_dec[3:0];
        valid_d[s_sel_q] = 1'b1;
        err_d[s_sel_q]   = 1'b0;
      end else begin
        valid_d[s_sel_q] = 1'b0;
        err_d[s_sel_q]   = !w_blank;
      end
`ifdef SEG_DP_EN
      dp_d[s_sel_q] = ~s_dp_q;
`endif
      // Closing a frame empties seen in the same edge so the next latch opens a new one.
      if (&seen_d) begin
        seen_d       = '0;
        frame_done_d = 1'b1;
      end
    end

    if (bus.clear) begin
      cnt_d        = 8'd0;
      state_d      = ST_IDLE;
      value_d      = '{default: 4'h0};
      valid_d      = '0;
      err_d        = '0;
      seen_d       = '0;
      frame_done_d = 1'b0;
`ifdef SEG_DP_EN
      dp_d         = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_seg_q      <= 7'h00;
      s_sel_q      <= '0;
      s_en_q       <= 1'b0;
      prev_q       <= '0;
      cnt_q        <= 8'd0;
      state_q      <= ST_IDLE;
      value_q      <= '{default: 4'h0};
      valid_q      <= '0;
      err_q        <= '0;
      seen_q       <= '0;
      frame_done_q <= 1'b0;
`ifdef SEG_DP_EN
      s_dp_q       <= 1'b0;
      dp_q         <= '0;
`endif
    end else begin
      s_seg_q      <= s_seg_d;
      s_sel_q      <= s_sel_d;
      s_en_q       <= s_en_d;
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      value_q      <= value_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      seen_q       <= seen_d;
      frame_done_q <= frame_done_d;
`ifdef SEG_DP_EN
      s_dp_q       <= s_dp_d;
      dp_q         <= dp_d;
`endif
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_value_out
    assign bus.value_out[4*k +: 4] = value_q[k];
  end
  assign bus.valid_mask = valid_q;
  assign bus.err_mask   = err_q;
  assign bus.frame_done = frame_done_q;
`ifdef SEG_DP_EN
  assign bus.dp_mask    = dp_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg_pattern_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_seg_pattern_decoder                                              |
// | Directed scenarios plus random scans against a run-length model.    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_seg_pattern_decoder;
  localparam int ND = 4;
  localparam int SC = 4;
  localparam int SW = $clog2(ND);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_pattern_decoder_if #(.NUM_DIGITS(ND)) bus ();
  seg_pattern_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic          brk;
    logic          en;
    logic          dp;
    logic [6:0]    seg;
    logic [SW-1:0] sel;
  } smp_t;

  smp_t          hist[$];
  logic [3:0]    m_val [ND];
  logic [ND-1:0] m_valid, m_err, m_seen, m_dp;
  logic          m_frame;
  logic          cur_dp;
  int            n_tests = 0;
  int            n_fail  = 0;

  logic [6:0] pat_tab [16] = '{
    7'b0000001, 7'b1111001, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // ---------------- reference model: latch when the run ending at the
  // evaluated sample is exactly SC identical enabled samples long.
  function automatic smp_t brk_smp();
    smp_t s = '0;
    s.brk = 1'b1;
    return s;
  endfunction

  task automatic model_reset();
    hist.delete();
    hist.push_back(brk_smp());
    for (int k = 0; k < ND; k++) m_val[k] = 4'h0;
    m_valid = '0; m_err = '0; m_seen = '0; m_dp = '0; m_frame = 1'b0;
  endtask

  function automatic logic same_key(input smp_t a, input smp_t b);
`ifdef SEG_DP_EN
    return (a.seg == b.seg) && (a.sel == b.sel) && (a.dp == b.dp);
`else
    return (a.seg == b.seg) && (a.sel == b.sel);
`endif
  endfunction

  task automatic apply_latch(input smp_t s);
    int idx;
    idx = -1;
    for (int p = 0; p < 16; p++) if (pat_tab[p] == s.seg) idx = p;
    m_seen[s.sel] = 1'b1;
    m_dp[s.sel]   = ~s.dp;
    if (idx >= 0) begin
      m_val[s.sel]   = 4'(idx);
      m_valid[s.sel] = 1'b1;
      m_err[s.sel]   = 1'b0;
    end else begin
      m_valid[s.sel] = 1'b0;
      m_err[s.sel]   = (s.seg != 7'b1111111);
    end
    if (&m_seen) begin
      m_seen  = '0;
      m_frame = 1'b1;
    end
  endtask

  task automatic model_edge();
    int   run;
    smp_t last;
    smp_t now;
    if (!rst) begin
      model_reset();
    end else begin
      m_frame = 1'b0;
      if (bus.clear) begin
        for (int k = 0; k < ND; k++) m_val[k] = 4'h0;
        m_valid = '0; m_err = '0; m_seen = '0; m_dp = '0;
        hist.push_back(brk_smp());
      end else begin
        run  = 0;
        last = hist[$];
        if (!last.brk && last.en) begin
          for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i].brk || !hist[i].en || !same_key(hist[i], last)) break;
            run++;
          end
        end
        if (run == SC) apply_latch(last);
      end
      now     = '0;
      now.en  = bus.dig_en && (int'(bus.dig_sel) < ND);
      now.seg = bus.seg_in;
      now.sel = bus.dig_sel;
      now.dp  = cur_dp;
      hist.push_back(now);
      if (hist.size() > 64) void'(hist.pop_front());
    end
  endtask

  function automatic logic [4*ND-1:0] exp_value();
    logic [4*ND-1:0] v;
    for (int k = 0; k < ND; k++) v[4*k +: 4] = m_val[k];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input int sel, input logic [6:0] seg, input logic en, input logic dp);
    bus.dig_sel = SW'(sel);
    bus.seg_in  = seg;
    bus.dig_en  = en;
    cur_dp      = dp;
`ifdef SEG_DP_EN
    bus.seg_dp  = dp;
`endif
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  // ---------------- scenarios
  task automatic test_reset();
    rst = 1'b0;
    bus.clear = 1'b0;
    drive(0, 7'h7F, 1'b0, 1'b1);
    model_reset();
    tick(); tick();
    n_tests++;
    if (bus.value_out !== '0 || bus.valid_mask !== '0 || bus.err_mask !== '0 || bus.frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: value=%h valid=%b err=%b fd=%b, required all zero",
               bus.value_out, bus.valid_mask, bus.err_mask, bus.frame_done);
    end
`ifdef SEG_DP_EN
    n_tests++;
    if (bus.dp_mask !== '0) begin
      n_fail++;
      $display("FAIL reset_dp: dp_mask=%b, required 0", bus.dp_mask);
    end
`endif
    #3 rst = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    drive(2, 7'b0010010, 1'b1, 1'b1);
    tick();
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_tests++;
      if (bus.valid_mask !== 4'b0000) begin
        n_fail++;
        $display("FAIL latency_early[%0d]: valid=%b, required 0000", i, bus.valid_mask);
      end
    end
    tick();
    n_tests++;
    if (bus.value_out[11:8] !== 4'h2 || bus.valid_mask !== 4'b0100) begin
      n_fail++;
      $display("FAIL latency_latch: digit2=%h valid=%b, required 2 and 0100",
               bus.value_out[11:8], bus.valid_mask);
    end
    tick();
  endtask

  task automatic test_short_run();
    drive(0, 7'b0000110, 1'b1, 1'b1);
    repeat (3) tick();
    drive(0, 7'b1001100, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_tests++;
      if (bus.valid_mask[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL short_run[%0d]: valid0=%b digit0=%h, required valid0=0",
                 i, bus.valid_mask[0], bus.value_out[3:0]);
      end
    end
    tick();
    n_tests++;
    if (bus.value_out[3:0] !== 4'h4 || bus.valid_mask[0] !== 1'b1 || bus.err_mask[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL short_run_latch: digit0=%h valid0=%b err0=%b, required 4/1/0",
               bus.value_out[3:0], bus.valid_mask[0], bus.err_mask[0]);
    end
  endtask

  task automatic test_illegal_and_blank();
    drive(1, 7'b0001111, 1'b1, 1'b1);
    repeat (5) tick();
    n_tests++;
    if (bus.value_out[7:4] !== 4'h7 || bus.valid_mask[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL legal_prep: digit1=%h valid1=%b, required 7/1", bus.value_out[7:4], bus.valid_mask[1]);
    end
    drive(1, 7'b1010101, 1'b1, 1'b1);
    repeat (5) tick();
    n_tests++;
    if (bus.err_mask[1] !== 1'b1 || bus.valid_mask[1] !== 1'b0 || bus.value_out[7:4] !== 4'h7) begin
      n_fail++;
      $display("FAIL illegal: err1=%b valid1=%b digit1=%h, required 1/0/7",
               bus.err_mask[1], bus.valid_mask[1], bus.value_out[7:4]);
    end
    drive(1, 7'b1111111, 1'b1, 1'b1);
    repeat (5) tick();
    n_tests++;
    if (bus.err_mask[1] !== 1'b0 || bus.valid_mask[1] !== 1'b0 || bus.value_out[7:4] !== 4'h7) begin
      n_fail++;
      $display("FAIL blank: err1=%b valid1=%b digit1=%h, required 0/0/7",
               bus.err_mask[1], bus.valid_mask[1], bus.value_out[7:4]);
    end
  endtask

  task automatic test_frame();
    int pulses;
    int at_digit;
    int at_cycle;
    pulse_clear();
    n_tests++;
    if (bus.valid_mask !== '0 || bus.err_mask !== '0 || bus.value_out !== '0) begin
      n_fail++;
      $display("FAIL clear: value=%h valid=%b err=%b, required all zero",
               bus.value_out, bus.valid_mask, bus.err_mask);
    end
    pulses = 0; at_digit = -1; at_cycle = -1;
    for (int d = 0; d < ND; d++) begin
      drive(d, pat_tab[d+1], 1'b1, 1'b1);
      for (int c = 1; c <= 5; c++) begin
        tick();
        if (bus.frame_done === 1'b1) begin
          pulses++; at_digit = d; at_cycle = c;
        end
      end
    end
    drive(0, 7'h7F, 1'b0, 1'b1);
    repeat (3) begin
      tick();
      if (bus.frame_done === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses != 1 || at_digit != 3 || at_cycle != 5) begin
      n_fail++;
      $display("FAIL frame_pulse: pulses=%0d at digit %0d cycle %0d, required 1 at digit 3 cycle 5",
               pulses, at_digit, at_cycle);
    end
    n_tests++;
    if (bus.value_out !== 16'h4321 || bus.valid_mask !== 4'b1111 || bus.err_mask !== 4'b0000) begin
      n_fail++;
      $display("FAIL frame_values: value=%h valid=%b err=%b, required 4321/1111/0000",
               bus.value_out, bus.valid_mask, bus.err_mask);
    end
  endtask

  task automatic test_clear_on_latch();
    for (int d = 0; d < ND - 1; d++) begin
      drive(d, pat_tab[d+5], 1'b1, 1'b1);
      repeat (5) tick();
    end
    drive(3, pat_tab[9], 1'b1, 1'b1);
    repeat (4) tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    n_tests++;
    if (bus.frame_done !== 1'b0 || bus.valid_mask !== '0 || bus.err_mask !== '0 || bus.value_out !== '0) begin
      n_fail++;
      $display("FAIL clear_on_latch: fd=%b value=%h valid=%b err=%b, required all zero",
               bus.frame_done, bus.value_out, bus.valid_mask, bus.err_mask);
    end
    drive(3, 7'h7F, 1'b0, 1'b1);
    tick();
    n_tests++;
    if (bus.frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_suppress: fd=%b, required 0", bus.frame_done);
    end
  endtask

  task automatic test_async_reset();
    drive(0, pat_tab[1], 1'b1, 1'b0);
    repeat (5) tick();
    n_tests++;
    if (bus.valid_mask !== 4'b0001 || bus.value_out[3:0] !== 4'h1) begin
      n_fail++;
      $display("FAIL pre_reset: valid=%b digit0=%h, required 0001/1", bus.valid_mask, bus.value_out[3:0]);
    end
    drive(1, pat_tab[2], 1'b1, 1'b1);
    repeat (2) tick();
    #1 rst = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (bus.value_out !== '0 || bus.valid_mask !== '0 || bus.err_mask !== '0 || bus.frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: value=%h valid=%b err=%b fd=%b, required all zero",
               bus.value_out, bus.valid_mask, bus.err_mask, bus.frame_done);
    end
`ifdef SEG_DP_EN
    n_tests++;
    if (bus.dp_mask !== '0) begin
      n_fail++;
      $display("FAIL async_reset_dp: dp_mask=%b, required 0", bus.dp_mask);
    end
`endif
    #1 rst = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_tests++;
      if (bus.valid_mask !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_restart[%0d]: valid=%b, required 0000", i, bus.valid_mask);
      end
    end
    tick();
    n_tests++;
    if (bus.valid_mask !== 4'b0010 || bus.value_out[7:4] !== 4'h2) begin
      n_fail++;
      $display("FAIL reset_relatch: valid=%b digit1=%h, required 0010/2", bus.valid_mask, bus.value_out[7:4]);
    end
  endtask

`ifdef SEG_DP_EN
  task automatic test_dp();
    drive(0, 7'b0000000, 1'b1, 1'b0);
    repeat (5) tick();
    n_tests++;
    if (bus.value_out[3:0] !== 4'h8 || bus.dp_mask[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL dp_latch: digit0=%h dp0=%b, required 8/1", bus.value_out[3:0], bus.dp_mask[0]);
    end
    drive(0, 7'b0000000, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_tests++;
      if (bus.dp_mask[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL dp_restart[%0d]: dp0=%b, required 1", i, bus.dp_mask[0]);
      end
    end
    tick();
    n_tests++;
    if (bus.dp_mask[0] !== 1'b0 || bus.value_out[3:0] !== 4'h8) begin
      n_fail++;
      $display("FAIL dp_relatch: dp0=%b digit0=%h, required 0/8", bus.dp_mask[0], bus.value_out[3:0]);
    end
  endtask
`endif

  task automatic test_random();
    int         sel;
    int         r;
    int         len;
    logic [6:0] seg;
    pulse_clear();
    for (int n = 0; n < 250; n++) begin
      sel = $urandom_range(0, ND - 1);
      r   = $urandom_range(0, 99);
      if (r < 70)      seg = pat_tab[$urandom_range(0, 15)];
      else if (r < 80) seg = 7'h7F;
      else             seg = 7'($urandom);
      len = $urandom_range(1, SC + 3);
      drive(sel, seg, ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)));
      for (int c = 0; c < len; c++) begin
        bus.clear = ($urandom_range(0, 39) == 0);
        tick();
        bus.clear = 1'b0;
        n_tests++;
        if (bus.value_out !== exp_value() || bus.valid_mask !== m_valid ||
            bus.err_mask !== m_err || bus.frame_done !== m_frame) begin
          n_fail++;
          $display("FAIL random[%0d]: got value=%h valid=%b err=%b fd=%b, required value=%h valid=%b err=%b fd=%b",
                   n, bus.value_out, bus.valid_mask, bus.err_mask, bus.frame_done,
                   exp_value(), m_valid, m_err, m_frame);
        end
`ifdef SEG_DP_EN
        n_tests++;
        if (bus.dp_mask !== m_dp) begin
          n_fail++;
          $display("FAIL random_dp[%0d]: got dp_mask=%b, required %b", n, bus.dp_mask, m_dp);
        end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_short_run();
    test_illegal_and_blank();
    test_frame();
    test_clear_on_latch();
    test_async_reset();
`ifdef SEG_DP_EN
    test_dp();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
